y_bank_writer: RTL

Y_BANK_WRITER -- requirements
Module: y_bank_writer

---
 rtl/y_bank_writer_pkg.sv | 15 +
 rtl/y_bank_writer_if.sv | 31 +++
 rtl/y_bank_writer_requant_sat.sv | 30 +++
 rtl/y_bank_writer.sv | 85 ++++++++
 4 files changed

// File: rtl/y_bank_writer_pkg.sv
// Shared definitions for the Y bank writer and the argmax reader that consumes its RAM.
package y_bank_writer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } ybw_state_t;

    localparam int DEF_W     = 16;
    localparam int DEF_ACC_W = 32;
    localparam int DEF_SHIFT = 8;

endpackage

// File: rtl/y_bank_writer_if.sv
// Accumulator stream in, Y RAM write port out, plus frame status.
interface y_bank_writer_if
    import y_bank_writer_pkg::*;
#(
    parameter int ACC_W = DEF_ACC_W,
    parameter int W     = DEF_W,
    parameter int Y_AW  = 2
) ();
    logic             start;
    logic             in_valid;
    logic             in_ready;
    logic [ACC_W-1:0] in_data;
    logic             in_last;
    logic             y_cs;
    logic             y_we;
    logic [Y_AW-1:0]  y_addr;
    logic [W-1:0]     y_din;
    logic             busy;
    logic             done;
    logic             err_len;

    modport master (
        output start, in_valid, in_data, in_last,
        input  in_ready, y_cs, y_we, y_addr, y_din, busy, done, err_len
    );

    modport slave (
        input  start, in_valid, in_data, in_last,
        output in_ready, y_cs, y_we, y_addr, y_din, busy, done, err_len
    );
endinterface

// File: rtl/y_bank_writer_requant_sat.sv
// Requantise a signed accumulator: round-half-up right shift, then saturate to W bits.
module requant_sat
    import y_bank_writer_pkg::*;
#(
    parameter int ACC_W = DEF_ACC_W,
    parameter int W     = DEF_W,
    parameter int SHIFT = DEF_SHIFT
) (
    input  logic signed [ACC_W-1:0] x,
    output logic signed [W-1:0]     q
);
    // One guard bit keeps the rounding add from overflowing at the positive extreme.
    localparam logic signed [ACC_W:0] RND  = {{(ACC_W+1-SHIFT){1'b0}}, 1'b1, {(SHIFT-1){1'b0}}};
    localparam logic signed [ACC_W:0] MAXV = {{(ACC_W+2-W){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [ACC_W:0] MINV = {{(ACC_W+2-W){1'b1}}, {(W-1){1'b0}}};

    logic signed [ACC_W:0] sum;
    logic signed [ACC_W:0] r;

    always_comb begin
        sum = $signed({x[ACC_W-1], x}) + RND;
        r   = sum >>> SHIFT;
        if (r > MAXV)
            q = MAXV[W-1:0];
        else if (r < MINV)
            q = MINV[W-1:0];
        else
            q = r[W-1:0];
    end
endmodule

// File: rtl/y_bank_writer.sv
// Writes one frame of requantised scores into Y RAM, then pulses done to start argmax.
module y_bank_writer
    import y_bank_writer_pkg::*;
#(
    parameter int N     = 4,
    parameter int W     = DEF_W,
    parameter int Y_AW  = 2,
    parameter int ACC_W = DEF_ACC_W,
    parameter int SHIFT = DEF_SHIFT
) (
    input logic            clk,
    input logic            rst,
    y_bank_writer_if.slave bus
);
    localparam logic [Y_AW-1:0] LAST_IDX = Y_AW'(N - 1);

    ybw_state_t        state, state_nxt;
    logic [Y_AW-1:0]   count;
    logic              accept;
    logic              at_last_idx;
    logic              frame_end;
    logic              len_bad;
    logic              open_frame;
    logic signed [W-1:0] q;

    requant_sat #(.ACC_W(ACC_W), .W(W), .SHIFT(SHIFT)) u_requant (
        .x (bus.in_data),
        .q (q)
    );

    assign bus.in_ready = (state == ST_FILL);
    assign bus.busy     = (state != ST_IDLE);
    assign bus.done     = (state == ST_DONE);

    assign open_frame  = (state == ST_IDLE) && bus.start;
    assign accept      = bus.in_valid && bus.in_ready;
    assign at_last_idx = (count == LAST_IDX);
    assign frame_end   = accept && (at_last_idx || bus.in_last);
    assign len_bad     = accept && (at_last_idx != bus.in_last);

    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (bus.start) state_nxt = ST_FILL;
            ST_FILL:  if (frame_end) state_nxt = ST_FLUSH;
            ST_FLUSH: state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // The RAM write for a beat lands one cycle after it is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            count       <= '0;
            bus.y_cs    <= 1'b0;
            bus.y_we    <= 1'b0;
            bus.y_addr  <= '0;
            bus.y_din   <= '0;
            bus.err_len <= 1'b0;
        end else begin
            bus.y_cs <= accept;
            bus.y_we <= accept;
            if (accept) begin
                bus.y_addr <= count;
                bus.y_din  <= q;
            end
            if (open_frame)
                count <= '0;
            else if (accept)
                count <= count + 1'b1;
            if (open_frame)
                bus.err_len <= 1'b0;
            else if (len_bad)
                bus.err_len <= 1'b1;
        end
    end
endmodule
